// File: rtl/mem_access_stage_if.sv
// Data-memory port of the MEM stage.
//   dmem_req   : access request, held until ready or abort
//   dmem_we    : 1 = write, 0 = read
//   dmem_addr  : access address
//   dmem_wdata : store data
//   dmem_rdata : load data, valid when dmem_req && dmem_ready
//   dmem_ready : access completion
// The master modport is the CPU side; the slave modport is the memory side.
interface mem_access_stage_if #(
  parameter int DATA_W = 16
);
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ready;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ready
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM-stage controller of the 16-bit pipelined CPU.
// ALU results pass straight into the MEM/WB register. Loads and stores are
// run on the data-memory port with a req/ready handshake, stalling the
// upstream pipeline while the access is pending. If memory does not answer
// within TIMEOUT+1 wait cycles the access is aborted and bus_err_out is set.
// Ports:
//   clk, reset        : clock, async active-high reset
//   alu_result_in     : ALU result / effective address from EX/MEM
//   store_data_in     : store data from EX/MEM
//   rd_in             : destination register
//   reg_write_in, mem_read_in, mem_write_in : EX/MEM control bits
//   stall_out         : combinational hold request to EX/MEM and earlier
//   dmem              : data-memory port (master side)
//   wb_data_out, wb_rd_out, wb_reg_write_out : MEM/WB register
//   bus_err_out       : sticky timeout flag
module mem_access_stage #(
  parameter int DATA_W  = 16,
  parameter int RD_W    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  alu_result_in,
  input  logic [DATA_W-1:0]  store_data_in,
  input  logic [RD_W-1:0]    rd_in,
  input  logic               reg_write_in,
  input  logic               mem_read_in,
  input  logic               mem_write_in,
  output logic               stall_out,
  mem_access_stage_if.master dmem,
  output logic [DATA_W-1:0]  wb_data_out,
  output logic [RD_W-1:0]    wb_rd_out,
  output logic               wb_reg_write_out,
  output logic               bus_err_out
);

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  // Write-back info of the access in flight.
  typedef struct packed {
    logic [RD_W-1:0] rd;
    logic            reg_write;
    logic            load;
  } pend_t;

  state_t     state, state_nxt;
  pend_t      pend;
  logic [7:0] cnt;
  logic       access, timed_out;

  assign access    = mem_read_in | mem_write_in;
  assign timed_out = (cnt == TMO);

  always_comb begin
    state_nxt = state;
    stall_out = 1'b0;
    case (state)
      S_IDLE:
        if (access) begin
          stall_out = 1'b1;
          state_nxt = S_WAIT;
        end
      S_WAIT:
        // Completion and abort both release EX/MEM in the same cycle.
        if (dmem.dmem_ready || timed_out) state_nxt = S_IDLE;
        else                              stall_out = 1'b1;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= S_IDLE;
      pend             <= '0;
      cnt              <= '0;
      dmem.dmem_req    <= 1'b0;
      dmem.dmem_we     <= 1'b0;
      dmem.dmem_addr   <= '0;
      dmem.dmem_wdata  <= '0;
      wb_data_out      <= '0;
      wb_rd_out        <= '0;
      wb_reg_write_out <= 1'b0;
      bus_err_out      <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE:
          if (!access) begin
            wb_data_out      <= alu_result_in;
            wb_rd_out        <= rd_in;
            wb_reg_write_out <= reg_write_in;
          end else begin
            // Write wins when both control bits are set; stores never write back.
            pend.rd          <= rd_in;
            pend.reg_write   <= reg_write_in & ~mem_write_in;
            pend.load        <= ~mem_write_in;
            dmem.dmem_addr   <= alu_result_in;
            dmem.dmem_wdata  <= store_data_in;
            dmem.dmem_we     <= mem_write_in;
            dmem.dmem_req    <= 1'b1;
            cnt              <= '0;
            wb_reg_write_out <= 1'b0;
          end
        S_WAIT:
          if (dmem.dmem_ready) begin
            dmem.dmem_req    <= 1'b0;
            wb_rd_out        <= pend.rd;
            wb_data_out      <= pend.load ? dmem.dmem_rdata : dmem.dmem_addr;
            wb_reg_write_out <= pend.reg_write;
          end else if (timed_out) begin
            dmem.dmem_req    <= 1'b0;
            bus_err_out      <= 1'b1;
            wb_reg_write_out <= 1'b0;
          end else begin
            cnt              <= cnt + 8'd1;
            wb_reg_write_out <= 1'b0;
          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  logic        clk, reset;
  logic [15:0] alu_result_in, store_data_in;
  logic [3:0]  rd_in;
  logic        reg_write_in, mem_read_in, mem_write_in;
  logic        stall_out;
  logic [15:0] wb_data_out;
  logic [3:0]  wb_rd_out;
  logic        wb_reg_write_out, bus_err_out;

  mem_access_stage_if #(.DATA_W(16)) dm ();

  mem_access_stage #(.DATA_W(16), .RD_W(4), .TIMEOUT(255)) dut (
    .clk              (clk),
    .reset            (reset),
    .alu_result_in    (alu_result_in),
    .store_data_in    (store_data_in),
    .rd_in            (rd_in),
    .reg_write_in     (reg_write_in),
    .mem_read_in      (mem_read_in),
    .mem_write_in     (mem_write_in),
    .stall_out        (stall_out),
    .dmem             (dm.master),
    .wb_data_out      (wb_data_out),
    .wb_rd_out        (wb_rd_out),
    .wb_reg_write_out (wb_reg_write_out),
    .bus_err_out      (bus_err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One instruction plus the memory behaviour it sees and what must come out.
  // lat = number of low-ready request cycles before ready; >255 means never.
  typedef struct {
    logic [15:0] alu, sd;
    logic [3:0]  rd;
    logic        rw, mr, mw;
    int          lat;
    logic [15:0] rdata;
    logic [15:0] e_data;
    logic [3:0]  e_rd;
    logic        e_rw, e_we;
    int          e_stall;
    logic        e_err;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  logic err_m  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] alu, sd, input logic [3:0] rd,
                              input logic rw, mr, mw, input int lat, input logic [15:0] rdata,
                              input logic [15:0] e_data, input logic [3:0] e_rd,
                              input logic e_rw, e_we, input int e_stall, input logic e_err);
    vec_t v;
    v.alu = alu; v.sd = sd; v.rd = rd; v.rw = rw; v.mr = mr; v.mw = mw;
    v.lat = lat; v.rdata = rdata;
    v.e_data = e_data; v.e_rd = e_rd; v.e_rw = e_rw; v.e_we = e_we;
    v.e_stall = e_stall; v.e_err = e_err;
    return v;
  endfunction

  // Reference: transaction-level outcome of one instruction.
  function automatic vec_t ref_model(input vec_t v, input logic err_in);
    bit acc, st, to;
    acc = v.mr | v.mw;
    st  = v.mw;
    to  = acc && (v.lat > 255);
    v.e_data  = !acc ? v.alu : (st ? v.alu : v.rdata);
    v.e_rd    = v.rd;
    v.e_rw    = acc ? ((st || to) ? 1'b0 : v.rw) : v.rw;
    v.e_we    = v.mw;
    v.e_stall = !acc ? 0 : (to ? 256 : v.lat + 1);
    v.e_err   = err_in | to;
    return v;
  endfunction

  task automatic idle_inputs();
    alu_result_in = '0; store_data_in = '0; rd_in = '0;
    reg_write_in = 0; mem_read_in = 0; mem_write_in = 0;
  endtask

  // Called and returns at a negedge with the DUT idle.
  task automatic do_op(input vec_t v);
    int k, stalls;
    bit done, to;
    alu_result_in = v.alu; store_data_in = v.sd; rd_in = v.rd;
    reg_write_in = v.rw; mem_read_in = v.mr; mem_write_in = v.mw;
    dm.dmem_ready = 1'($urandom_range(0, 1));   // ignored while req is low
    dm.dmem_rdata = 16'($urandom);
    #1;
    stalls = int'(stall_out);
    if (!(v.mr | v.mw)) begin
      @(posedge clk); @(negedge clk);
      chk("alu_req", dm.dmem_req, 0);
    end else begin
      @(posedge clk); @(negedge clk);
      k = 0; done = 0; to = 0;
      while (!done) begin
        chk("wait_req", dm.dmem_req, 1);
        chk("wait_addr", dm.dmem_addr, v.alu);
        chk("wait_wdata", dm.dmem_wdata, v.sd);
        chk("wait_we", dm.dmem_we, v.e_we);
        chk("wait_wb_rw", wb_reg_write_out, 0);
        // EX/MEM moves on underneath; the stage must ignore it.
        alu_result_in = 16'($urandom); store_data_in = 16'($urandom);
        rd_in = 4'($urandom); reg_write_in = 1'($urandom);
        mem_read_in = 1'($urandom); mem_write_in = 1'($urandom);
        if (k == v.lat) begin
          dm.dmem_ready = 1; dm.dmem_rdata = v.rdata; done = 1;
        end else begin
          dm.dmem_ready = 0; dm.dmem_rdata = 16'($urandom);
          if (k == 255) begin done = 1; to = 1; end
        end
        #1;
        stalls += int'(stall_out);
        @(posedge clk); @(negedge clk);
        k++;
        dm.dmem_ready = 0;
      end
      chk("done_req", dm.dmem_req, 0);
    end
    chk("stall_cycles", stalls, v.e_stall);
    chk("wb_rw", wb_reg_write_out, v.e_rw);
    chk("bus_err", bus_err_out, v.e_err);
    if (!to) begin
      chk("wb_data", wb_data_out, v.e_data);
      chk("wb_rd", wb_rd_out, v.e_rd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  vec_t tbl[8];
  vec_t v;

  initial begin
    //        alu      sd        rd rw mr mw lat   rdata     e_data    e_rd rw we stall err
    tbl[0] = mk(16'h1234, 16'h0000, 3, 1, 0, 0, 0,    16'h0000, 16'h1234, 3, 1, 0, 0,   0);
    tbl[1] = mk(16'h0040, 16'h0000, 5, 1, 1, 0, 0,    16'hBEEF, 16'hBEEF, 5, 1, 0, 1,   0);
    tbl[2] = mk(16'h0100, 16'hA5A5, 7, 1, 0, 1, 2,    16'h1111, 16'h0100, 7, 0, 1, 3,   0);
    tbl[3] = mk(16'h0200, 16'h5555, 2, 1, 1, 1, 1,    16'h9999, 16'h0200, 2, 0, 1, 2,   0);
    tbl[4] = mk(16'h0010, 16'h0000, 0, 1, 1, 0, 0,    16'h7777, 16'h7777, 0, 1, 0, 1,   0);
    tbl[5] = mk(16'h0077, 16'h0000, 4, 0, 0, 0, 0,    16'h0000, 16'h0077, 4, 0, 0, 0,   0);
    tbl[6] = mk(16'h0300, 16'h0000, 9, 1, 1, 0, 1000, 16'hDEAD, 16'h0000, 0, 0, 0, 256, 1);
    tbl[7] = mk(16'hCAFE, 16'h0000, 1, 1, 0, 0, 0,    16'h0000, 16'hCAFE, 1, 1, 0, 0,   1);

    reset = 1;
    idle_inputs();
    dm.dmem_ready = 0; dm.dmem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_req", dm.dmem_req, 0);
    chk("rst_we", dm.dmem_we, 0);
    chk("rst_addr", dm.dmem_addr, 0);
    chk("rst_wdata", dm.dmem_wdata, 0);
    chk("rst_wb_data", wb_data_out, 0);
    chk("rst_wb_rd", wb_rd_out, 0);
    chk("rst_wb_rw", wb_reg_write_out, 0);
    chk("rst_err", bus_err_out, 0);
    chk("rst_stall", stall_out, 0);
    reset = 0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) do_op(tbl[i]);
    err_m = 1'b1;

    // Reset in the middle of a pending load.
    alu_result_in = 16'h0500; rd_in = 4'd6; reg_write_in = 1; mem_read_in = 1;
    dm.dmem_ready = 0;
    @(posedge clk); @(negedge clk);
    idle_inputs();
    @(posedge clk); @(negedge clk);
    chk("mid_req", dm.dmem_req, 1);
    reset = 1;
    #1;
    chk("mr_req", dm.dmem_req, 0);
    chk("mr_addr", dm.dmem_addr, 0);
    chk("mr_we", dm.dmem_we, 0);
    chk("mr_wb_data", wb_data_out, 0);
    chk("mr_wb_rd", wb_rd_out, 0);
    chk("mr_wb_rw", wb_reg_write_out, 0);
    chk("mr_err", bus_err_out, 0);
    @(posedge clk); @(negedge clk);
    reset = 0;
    err_m = 1'b0;
    @(negedge clk);
    v = ref_model(mk(16'h0444, 16'h0, 4'd8, 1, 1, 0, 1, 16'h4321, 0, 0, 0, 0, 0, 0), err_m);
    do_op(v);
    err_m = v.e_err;

    for (int i = 0; i < 60; i++) begin
      v.alu = 16'($urandom); v.sd = 16'($urandom); v.rd = 4'($urandom);
      v.rw = 1'($urandom); v.mr = 1'($urandom); v.mw = 1'($urandom);
      v.lat = $urandom_range(0, 4); v.rdata = 16'($urandom);
      v = ref_model(v, err_m);
      do_op(v);
      err_m = v.e_err;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
